alu_mult_div: RTL and testbench

Iterative HI/LO multiply/divide unit in the execute stage. Consumes the ALU function code produced by opcode decode and executes the HI/LO-class functions: `Alu_Func_Muls`, `Alu_Func_Mulu`, `Alu_Func_Divs`, `Alu_Func_Divu`, `Alu_Func_Mthi`, `Alu_Func_Mtlo`, `Alu_Func_Mfhi` and `Alu_Func_Mflo`. It holds the architectural HI/LO registers and stalls the pipeline through a ready/valid handshake while a multi-cycle operation runs.

---
 rtl/alu_mult_div_pkg.sv | 27 ++
 rtl/alu_mult_div_if.sv | 30 +++
 rtl/alu_mult_div.sv | 166 ++++++++++++++++
 tb/tb_alu_mult_div.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mult_div_pkg.sv
// Shared types for the execute-stage HI/LO unit.
// Alu_Func_T is the function code produced by opcode decode.
package alu_mult_div_pkg;

  typedef enum logic [4:0] {
    Alu_Func_Add,
    Alu_Func_Sub,
    Alu_Func_And,
    Alu_Func_Or,
    Alu_Func_Xor,
    Alu_Func_Nor,
    Alu_Func_Slt,
    Alu_Func_Sltu,
    Alu_Func_Sll,
    Alu_Func_Srl,
    Alu_Func_Sra,
    Alu_Func_Muls,
    Alu_Func_Mulu,
    Alu_Func_Divs,
    Alu_Func_Divu,
    Alu_Func_Mthi,
    Alu_Func_Mtlo,
    Alu_Func_Mfhi,
    Alu_Func_Mflo
  } Alu_Func_T;

endpackage

// File: rtl/alu_mult_div_if.sv
// Issue/result bundle between the execute stage and the HI/LO unit.
// The master drives work in; the slave (the unit) reports status and HI/LO.
interface alu_mult_div_if #(
  parameter int WIDTH = 32
);
  import alu_mult_div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  Alu_Func_T        func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, func, a, b, abort,
    input  in_ready, busy, done, result, hi, lo
  );

  modport slave (
    input  in_valid, func, a, b, abort,
    output in_ready, busy, done, result, hi, lo
  );

endinterface

// File: rtl/alu_mult_div.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, followed by a sign-fix cycle.
module alu_mult_div
  import alu_mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clock,
  input logic            reset,
  alu_mult_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_araw;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_done;

  logic               w_busy;
  logic               w_accept;
  logic               w_is_md;
  logic               w_is_div;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_amag;
  logic [WIDTH-1:0]   w_bmag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = bus.in_valid & ~w_busy & ~bus.abort;
  assign w_is_div = (bus.func == Alu_Func_Divs)
                  | (bus.func == Alu_Func_Divu);
  assign w_is_md  = w_is_div
                  | (bus.func == Alu_Func_Muls)
                  | (bus.func == Alu_Func_Mulu);
  assign w_sgn    = (bus.func == Alu_Func_Muls)
                  | (bus.func == Alu_Func_Divs);

  assign w_amag = (w_sgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_bmag = (w_sgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // r_p holds {partial product, multiplier} or {remainder, quotient}
  assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                 + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_trial = r_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};

  assign w_q    = r_p[WIDTH-1:0];
  assign w_r    = r_p[2*WIDTH-1:WIDTH];
  assign w_prod = r_neg_q ? -r_p : r_p;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && w_is_md) w_next = S_RUN;
      S_RUN: begin
        if (bus.abort)         w_next = S_IDLE;
        else if (r_cnt == LAST) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b1;
    unique case (r_state)
      S_IDLE:  w_busy = 1'b0;
      default: w_busy = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_araw  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_md) begin
            r_p     <= {{WIDTH{1'b0}}, w_is_div ? w_amag : w_bmag};
            r_m     <= w_is_div ? w_bmag : w_amag;
            r_araw  <= bus.a;
            r_div   <= w_is_div;
            r_neg_q <= w_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r <= w_sgn & bus.a[WIDTH-1];
            r_dz    <= (bus.b == '0);
            r_cnt   <= '0;
          end else if (w_accept && bus.func == Alu_Func_Mthi) begin
            r_hi <= bus.a;
          end else if (w_accept && bus.func == Alu_Func_Mtlo) begin
            r_lo <= bus.a;
          end
        end
        S_RUN: begin
          if (!bus.abort) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div)
              r_p <= {w_trial[WIDTH] ? r_p[2*WIDTH-2:WIDTH-1]
                                     : w_trial[WIDTH-1:0],
                      r_p[WIDTH-2:0], ~w_trial[WIDTH]};
            else
              r_p <= {w_sum, r_p[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!bus.abort) begin
            r_done <= 1'b1;
            if (r_div && r_dz) begin
              r_lo <= '1;
              r_hi <= r_araw;
            end else if (r_div) begin
              r_lo <= r_neg_q ? -w_q : w_q;
              r_hi <= r_neg_r ? -w_r : w_r;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = ~w_busy;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.result   = (bus.func == Alu_Func_Mfhi) ? r_hi : r_lo;

endmodule

// File: tb/tb_alu_mult_div.sv
// Directed and randomized checks of the HI/LO unit against an
// arithmetic reference model of HI/LO.
module tb_alu_mult_div;
  import alu_mult_div_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;

  alu_mult_div_if #(.WIDTH(W)) bus ();

  alu_mult_div #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input Alu_Func_T f, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      Alu_Func_Mulu: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      Alu_Func_Muls: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      Alu_Func_Divu, Alu_Func_Divs: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else if (f == Alu_Func_Divu) begin
          m_lo = a / b;
          m_hi = a % b;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
      end
      Alu_Func_Mthi: m_hi = a;
      Alu_Func_Mtlo: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic do_md(input string tag, input Alu_Func_T f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    int done_in_busy;
    cyc = 0;
    done_in_busy = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = f;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model(f, a, b);
    @(negedge clk);
    chk({tag, " in_ready_low"}, W'(bus.in_ready), '0);
    while (bus.busy === 1'b1 && cyc < 100) begin
      if (bus.done !== 1'b0) done_in_busy++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, cyc, W'(W + 1));
    chk({tag, " done_in_busy"}, done_in_busy, '0);
    chk({tag, " done_pulse"}, W'(bus.done), W'(1));
    chk({tag, " hi"}, bus.hi, m_hi);
    chk({tag, " lo"}, bus.lo, m_lo);
    @(negedge clk);
    chk({tag, " done_clear"}, W'(bus.done), '0);
  endtask

  task automatic do_simple(input string tag, input Alu_Func_T f,
                           input logic [W-1:0] a);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = f;
    bus.a = a;
    bus.b = '0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model(f, a, '0);
    @(negedge clk);
    chk({tag, " hi"}, bus.hi, m_hi);
    chk({tag, " lo"}, bus.lo, m_lo);
    chk({tag, " result"}, bus.result,
        (f == Alu_Func_Mfhi) ? m_hi : m_lo);
    chk({tag, " busy"}, W'(bus.busy), '0);
  endtask

  Alu_Func_T ops [8];
  initial begin
    ops[0] = Alu_Func_Muls;
    ops[1] = Alu_Func_Mulu;
    ops[2] = Alu_Func_Divs;
    ops[3] = Alu_Func_Divu;
    ops[4] = Alu_Func_Mthi;
    ops[5] = Alu_Func_Mtlo;
    ops[6] = Alu_Func_Mfhi;
    ops[7] = Alu_Func_Mflo;
  end

  initial begin
    Alu_Func_T f;
    logic [W-1:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    bus.func = Alu_Func_Add;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy", W'(bus.busy), '0);
    chk("rst in_ready", W'(bus.in_ready), W'(1));
    chk("rst done", W'(bus.done), '0);
    chk("rst hi", bus.hi, '0);
    chk("rst lo", bus.lo, '0);
    rst = 1'b0;

    do_md("mulu_max", Alu_Func_Mulu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulu_max hi_lit", bus.hi, 32'hFFFFFFFE);
    chk("mulu_max lo_lit", bus.lo, 32'h00000001);
    do_md("muls_-3x5", Alu_Func_Muls, -32'sd3, 32'd5);
    do_md("divs_-7/2", Alu_Func_Divs, -32'sd7, 32'd2);
    chk("divs_-7/2 lo_lit", bus.lo, 32'hFFFFFFFD);
    do_md("divu_7/0", Alu_Func_Divu, 32'd7, 32'd0);
    do_md("divs_-7/0", Alu_Func_Divs, -32'sd7, 32'd0);
    do_md("divs_ovf", Alu_Func_Divs, 32'h80000000, 32'hFFFFFFFF);
    chk("divs_ovf lo_lit", bus.lo, 32'h80000000);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = Alu_Func_Mthi;
    bus.a = 32'h12345678;
    @(posedge clk);
    #1 model(Alu_Func_Mthi, 32'h12345678, '0);
    bus.func = Alu_Func_Mflo;
    @(negedge clk);
    chk("mflo result", bus.result, m_lo);
    chk("mflo busy", W'(bus.busy), '0);
    @(posedge clk);
    #1 bus.func = Alu_Func_Mfhi;
    @(negedge clk);
    chk("mfhi result", bus.result, 32'h12345678);
    chk("mfhi busy", W'(bus.busy), '0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = Alu_Func_Mthi;
    bus.a = 32'hDEADBEEF;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort hi", bus.hi, m_hi);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = Alu_Func_Divu;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort in_ready", W'(bus.in_ready), W'(1));
    chk("abort hi", bus.hi, m_hi);
    chk("abort lo", bus.lo, m_lo);
    chk("abort done", W'(bus.done), '0);
    @(negedge clk);
    chk("abort done2", W'(bus.done), '0);

    do_simple("mtlo_pre", Alu_Func_Mtlo, 32'hCAFEF00D);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = Alu_Func_Mulu;
    bus.a = 32'd3;
    bus.b = 32'd5;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst busy", W'(bus.busy), '0);
    chk("midrst hi", bus.hi, '0);
    chk("midrst lo", bus.lo, '0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    do_simple("post_rst_mfhi", Alu_Func_Mfhi, '0);

    for (int i = 0; i < 24; i++) begin
      f = ops[$urandom_range(0, 7)];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      if (f == Alu_Func_Muls || f == Alu_Func_Mulu ||
          f == Alu_Func_Divs || f == Alu_Func_Divu)
        do_md($sformatf("rnd%0d_%s", i, f.name()), f, ra, rb);
      else
        do_simple($sformatf("rnd%0d_%s", i, f.name()), f, ra);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
